// File: rtl/backend_pkg.sv
// Shared backend definitions: default dispatch width, decode payload and tag widths.
// Pure declarations, no logic, so there is no latency.
// Backpressure: not applicable.
//
// Contents: DISPATCH_WIDTH, UOP_W, SEQ_W, uop_t (packed decode payload), ptr_w().
package backend_pkg;

  localparam int DISPATCH_WIDTH = 2;
  localparam int UOP_W          = 128;
  localparam int SEQ_W          = 8;

  // Decoded micro-op. The field widths add up to exactly UOP_W (128 bits).
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [11:0] csr;
    logic [19:0] imm;
    logic [3:0]  fu_op;
    logic [2:0]  ldu_op;
    logic [1:0]  stu_op;
    logic [7:0]  flags;
  } uop_t;

  // Pointer width. The extra MSB tells a full queue apart from an empty one.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/lead_ones_cnt.sv
// Counts the contiguous run of ones starting at bit 0 of the input vector.
// Purely combinational, so the latency is 0 cycles.
// Backpressure: not applicable.
//
// Ports: bits [W] in, cnt [clog2(W+1)] out.
module lead_ones_cnt #(
  parameter int W  = 2,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  bits,
  output logic [CW-1:0] cnt
);

  logic stop;

  // The first zero ends the run. Ones above that zero are ignored.
  always_comb begin
    cnt  = '0;
    stop = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (!stop && bits[i]) begin
        cnt = cnt + CW'(1);
      end else begin
        stop = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dispatch_queue.sv
// In-order queue between decode and the ROB allocator. It moves up to WIDTH uops in and up to WIDTH uops out per cycle.
// Latency is 1 cycle at minimum from enqueue to dequeue. There is no bypass from the enqueue side to the dequeue side.
// Backpressure: lane k is ready only while more than k slots are free. trap/ret close the input. wfi holds the output.
//
// Ports: clk, rst (sync active-high), global_trap_i/global_ret_i (flush), global_wfi_i (dequeue hold),
//        enq_valid_i/enq_ready_o/enq_uop_i (decode side), deq_valid_o/deq_ready_i/deq_uop_o/deq_seq_o (ROB side),
//        count_o (registered occupancy).
module dispatch_queue #(
  parameter int WIDTH = backend_pkg::DISPATCH_WIDTH,
  parameter int DEPTH = 16,
  parameter int UOP_W = backend_pkg::UOP_W,
  parameter int SEQ_W = backend_pkg::SEQ_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   global_trap_i,
  input  logic                   global_ret_i,
  input  logic                   global_wfi_i,
  input  logic [WIDTH-1:0]       enq_valid_i,
  output logic [WIDTH-1:0]       enq_ready_o,
  input  logic [WIDTH*UOP_W-1:0] enq_uop_i,
  output logic [WIDTH-1:0]       deq_valid_o,
  input  logic [WIDTH-1:0]       deq_ready_i,
  output logic [WIDTH*UOP_W-1:0] deq_uop_o,
  output logic [WIDTH*SEQ_W-1:0] deq_seq_o,
  output logic [backend_pkg::ptr_w(DEPTH)-1:0] count_o
);

  localparam int PW = backend_pkg::ptr_w(DEPTH);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(WIDTH + 1);

  logic [UOP_W-1:0] mem_uop [DEPTH];
  logic [SEQ_W-1:0] mem_seq [DEPTH];

  logic [PW-1:0]    head_q, tail_q, count_q;
  logic [SEQ_W-1:0] seq_q;
  logic [PW-1:0]    free;
  logic             flush;
  logic [WIDTH-1:0] enq_hs, deq_hs;
  logic [CW-1:0]    n_enq, n_deq;

  assign flush = global_trap_i | global_ret_i;
  assign free  = PW'(DEPTH) - count_q;

  // Ready and valid are derived only from registered occupancy.
  // Ready is independent of enq_valid_i.
  // While rst is high, ready reports all ones and valid is held low. The reset branch below ignores any handshake in that cycle.
  for (genvar k = 0; k < WIDTH; k++) begin : g_lane
    assign enq_ready_o[k] = ((free > PW'(k)) | rst) & ~flush;
    assign deq_valid_o[k] = (count_q > PW'(k)) & ~global_wfi_i & ~rst;
    assign deq_uop_o[k*UOP_W +: UOP_W] = mem_uop[head_q[IW-1:0] + IW'(k)];
    assign deq_seq_o[k*SEQ_W +: SEQ_W] = mem_seq[head_q[IW-1:0] + IW'(k)];
  end

  assign enq_hs = enq_valid_i & enq_ready_o;
  assign deq_hs = deq_valid_o & deq_ready_i;

  // Only the leading run of handshaking lanes is taken. This keeps the order strict.
  lead_ones_cnt #(.W(WIDTH), .CW(CW)) u_enq_cnt (.bits(enq_hs), .cnt(n_enq));
  lead_ones_cnt #(.W(WIDTH), .CW(CW)) u_deq_cnt (.bits(deq_hs), .cnt(n_deq));

  // Payload storage. It has no reset, because the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    for (int j = 0; j < WIDTH; j++) begin
      if (CW'(j) < n_enq) begin
        mem_uop[tail_q[IW-1:0] + IW'(j)] <= enq_uop_i[j*UOP_W +: UOP_W];
        mem_seq[tail_q[IW-1:0] + IW'(j)] <= seq_q + SEQ_W'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      seq_q   <= '0;
    end else if (flush) begin
      // n_enq is already zero here because ready is masked during a flush.
      // The pops from this cycle are discarded together with everything else.
      // seq_q keeps counting from where it was.
      head_q  <= tail_q;
      count_q <= '0;
    end else begin
      tail_q  <= tail_q + PW'(n_enq);
      head_q  <= head_q + PW'(n_deq);
      count_q <= count_q + PW'(n_enq) - PW'(n_deq);
      seq_q   <= seq_q + SEQ_W'(n_enq);
    end
  end

  assign count_o = count_q;

endmodule

// File: tb/tb_dispatch_queue.sv
// Randomised and directed stimulus for dispatch_queue with WIDTH=2 and DEPTH=8, checked against a reference model built on a queue.
// Inputs change 1 time unit after the rising edge. Outputs are sampled 2 time units after the rising edge.
// Prints a single summary line at the end of the run.
module tb_dispatch_queue;

  localparam int W  = 2;
  localparam int D  = 8;
  localparam int UW = 128;
  localparam int SW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, trap, ret, wfi;
  logic [W-1:0]    enq_valid, enq_ready, deq_valid, deq_ready;
  logic [W*UW-1:0] enq_uop, deq_uop;
  logic [W*SW-1:0] deq_seq;
  logic [3:0]      count;

  dispatch_queue #(.WIDTH(W), .DEPTH(D), .UOP_W(UW), .SEQ_W(SW)) dut (
    .clk(clk), .rst(rst),
    .global_trap_i(trap), .global_ret_i(ret), .global_wfi_i(wfi),
    .enq_valid_i(enq_valid), .enq_ready_o(enq_ready), .enq_uop_i(enq_uop),
    .deq_valid_o(deq_valid), .deq_ready_i(deq_ready),
    .deq_uop_o(deq_uop), .deq_seq_o(deq_seq), .count_o(count)
  );

  typedef struct packed {
    logic [UW-1:0] uop;
    logic [SW-1:0] seq;
  } ent_t;

  ent_t          mq[$];
  logic [SW-1:0] mseq;
  int            checks   = 0;
  int            failures = 0;
  int            total_enq = 0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  // Runs one clock cycle: drives the inputs, checks every output against the model, then advances the model.
  task automatic cyc(input logic r, input logic t, input logic rt, input logic w,
                     input logic [W-1:0] ev, input logic [W-1:0] dr);
    logic [UW-1:0] u [W];
    logic [W-1:0]  er, dv;
    int            ne, nd, sz;
    @(posedge clk);
    #1;
    for (int k = 0; k < W; k++) begin
      u[k] = {$urandom(), $urandom(), $urandom(), $urandom()};
      enq_uop[k*UW +: UW] = u[k];
    end
    rst = r; trap = t; ret = rt; wfi = w; enq_valid = ev; deq_ready = dr;
    #1;
    sz = mq.size();
    for (int k = 0; k < W; k++) begin
      er[k] = ((D - sz > k) || r) && !t && !rt;
      dv[k] = (sz > k) && !w && !r;
    end
    chk("count", 128'(count), 128'(sz));
    chk("enq_ready", 128'(enq_ready), 128'(er));
    chk("deq_valid", 128'(deq_valid), 128'(dv));
    for (int k = 0; k < W; k++) begin
      if (dv[k]) begin
        chk("deq_uop", deq_uop[k*UW +: UW], mq[k].uop);
        chk("deq_seq", 128'(deq_seq[k*SW +: SW]), 128'(mq[k].seq));
      end
    end
    nd = 0;
    ne = 0;
    for (int k = 0; k < W; k++) begin
      if (nd == k && dv[k] && dr[k]) nd++;
      if (ne == k && er[k] && ev[k]) ne++;
    end
    if (r) begin
      mq.delete();
      mseq = '0;
    end else begin
      repeat (nd) void'(mq.pop_front());
      if (t || rt) begin
        mq.delete();
      end else begin
        for (int j = 0; j < ne; j++) begin
          mq.push_back('{uop: u[j], seq: mseq});
          mseq++;
          total_enq++;
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; trap = 1'b0; ret = 1'b0; wfi = 1'b0;
    enq_valid = '0; deq_ready = '0; enq_uop = '0;
    mseq = '0;
    mq.delete();
    cyc(1, 0, 0, 0, 2'b00, 2'b00);
    cyc(1, 0, 0, 0, 2'b11, 2'b11);

    // Two uops go in, come out one cycle later, and leave the queue empty.
    cyc(0, 0, 0, 0, 2'b11, 2'b00);
    cyc(0, 0, 0, 0, 2'b00, 2'b11);
    cyc(0, 0, 0, 0, 2'b00, 2'b00);

    // A gap on lane 0 blocks lane 1. Lane 0 on its own is accepted.
    cyc(0, 0, 0, 0, 2'b10, 2'b00);
    cyc(0, 0, 0, 0, 2'b01, 2'b00);

    // Fill to 7 entries, then offer 2 so only 1 is accepted.
    // Then pop 2 while the queue is full, and refill.
    repeat (3) cyc(0, 0, 0, 0, 2'b11, 2'b00);
    cyc(0, 0, 0, 0, 2'b11, 2'b00);
    cyc(0, 0, 0, 0, 2'b11, 2'b11);
    cyc(0, 0, 0, 0, 2'b11, 2'b00);

    // Pairs of enqueues and dequeues that make the head wrap past index 7.
    repeat (12) cyc(0, 0, 0, 0, 2'b11, 2'b11);

    // Trap with 5 entries resident. One uop pops in the same cycle. The sequence tag continues afterwards.
    repeat (4) cyc(0, 0, 0, 0, 2'b00, 2'b11);
    repeat (2) cyc(0, 0, 0, 0, 2'b11, 2'b00);
    cyc(0, 0, 0, 0, 2'b01, 2'b00);
    cyc(0, 1, 0, 0, 2'b11, 2'b01);
    cyc(0, 0, 0, 0, 2'b11, 2'b00);
    cyc(0, 0, 0, 0, 2'b00, 2'b11);

    // WFI hold with 4 entries resident. Enqueues still land during the hold.
    repeat (2) cyc(0, 0, 0, 0, 2'b11, 2'b00);
    repeat (3) cyc(0, 0, 0, 1, 2'b01, 2'b11);
    cyc(0, 0, 0, 0, 2'b00, 2'b11);

    // Flush arriving together with WFI, then a ret flush, then a reset in the middle of operation.
    cyc(0, 1, 0, 1, 2'b11, 2'b11);
    cyc(0, 0, 0, 0, 2'b11, 2'b00);
    cyc(0, 0, 1, 0, 2'b11, 2'b11);
    repeat (2) cyc(0, 0, 0, 0, 2'b11, 2'b00);
    cyc(1, 0, 0, 0, 2'b11, 2'b11);
    cyc(0, 0, 0, 0, 2'b11, 2'b00);

    // Random traffic. This is long enough for the 8-bit tag to wrap several times.
    for (int i = 0; i < 2000; i++) begin
      cyc(($urandom_range(0, 299) == 0),
          ($urandom_range(0, 39) == 0),
          ($urandom_range(0, 59) == 0),
          ($urandom_range(0, 7) == 0),
          W'($urandom()), W'($urandom()));
    end
    cyc(0, 0, 0, 0, 2'b00, 2'b00);

    if (total_enq < 300) begin
      failures++;
      $display("FAIL enq_volume actual=%0d expected_at_least=300", total_enq);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
